div_arbiter: RTL
================

// Module: div_arbiter
// PURPOSE
//  Shares one unsigned restoring shift-subtract divider between two requesters.
//  Each requester presents N/D with a level req. A round-robin arbiter grants
//  one request at a time and sequences the divider over WIDTH iterations.
//  Each client gets its own Q/R result registers and a done pulse.
//  Sits between the compute clients and the divide datapath (div_master style).
// PARAMETERS
//  WIDTH  8  operand/result width; also the number of divide iterations
// PORTS
//  clk        in   1      system clock, rising edge; single clock domain
//  rst        in   1      reset, asynchronous, active-high
//  req0/req1  in   1      client k requests a divide; level, held until ackk
//  n0/n1      in   WIDTH  client k dividend (unsigned), valid while reqk=1
//  d0/d1      in   WIDTH  client k divisor (unsigned), valid while reqk=1
//  ack0/ack1  out  1      1-cycle pulse: client k operands captured
//  done0/done1 out 1      1-cycle pulse: client k q/r/dz now valid
//  q0/q1      out  WIDTH  client k quotient; held until the next donek
//  r0/r1      out  WIDTH  client k remainder; held until the next donek
//  dz0/dz1    out  1      client k last op was divide-by-zero; held with q/r
//  busy       out  1      1 in any state other than IDLE
// BEHAVIOUR
//  Reset (async, any time, incl. mid-operation):
//   - state=IDLE, rr pointer=client 0 preferred.
//   - All outputs=0 (ack, done, q, r, dz, busy). In-flight op is discarded; no done.
//  FSM: IDLE -> ITER -> DONE -> IDLE; IDLE -> DONE directly on d==0.
//  IDLE:
//   - Neither req: stay.
//   - One req: grant it.
//   - Both req: grant the preferred client; preference then flips to the other.
//     Each grant sets preference to the non-granted client.
//   - Grant edge: latch n,d and owner; set A=0, Qs=n, cnt=WIDTH.
//   - ackk registered high for exactly the next cycle.
//   - Next state: ITER, or DONE if d==0.
//  ITER, one step per cycle:
//   - A(WIDTH+1b)={A[WIDTH-1:0],Qs[WIDTH-1]}; Qs<<=1.
//   - If A>=d: A-=d, Qs[0]=1.
//   - cnt-=1; go to DONE after the WIDTH-th step.
//  DONE, one cycle:
//   - Owner's q=Qs, r=A[WIDTH-1:0], dz=0; donek=1 for this cycle only.
//   - Then IDLE.
//   - Divide-by-zero: q={WIDTH{1'b1}}, r=n, dz=1.
//   - The other client's q/r/dz are untouched.
//  Latency, counted from the grant edge to the donek-high cycle:
//   - Normal: WIDTH+1 edges.
//   - d==0: 1 edge.
//   - Earliest next grant: the edge that leaves DONE.
//  Requests:
//   - A requester drops reqk on the edge after it sees ackk.
//   - If reqk is still high when IDLE is re-entered, it is a new request.
//   - n/d changes while not granted, or after grant, have no effect.
//  busy=1 in ITER and DONE. ack and done are never high together for the same op.
// TESTING
//  1. rst pulse; req0, n0=32, d0=3:
//     ack0 next cycle; done0 WIDTH+1 edges after grant; q0=10, r0=2, dz0=0.
//  2. req0 and req1 together from reset (n0=100/d0=7, n1=255/d1=1):
//     client0 first (q0=14, r0=2); then client1 (q1=255, r1=0).
//  3. Both held requesting continuously:
//     grants alternate 0,1,0,1; no client starves.
//  4. req1, n1=9, d1=0: done1 1 edge after grant; q1=8'hFF, r1=9, dz1=1.
//  5. Other edge values:
//     - n0=5, d0=7: q0=0, r0=5.
//     - n0=0, d0=4: q0=0, r0=0.
//     - n0=d0=200: q0=1, r0=0.
//  6. rst asserted mid-ITER: outputs 0 immediately, no done; new req after reset completes normally.

Source files
------------

// File: rtl/div_arbiter.sv
// Two-client front end for one restoring shift-subtract divider: round-robin grant,
// WIDTH iteration steps, per-client result registers and one-cycle done pulses.
module div_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] n0,
    input  logic [WIDTH-1:0] d0,
    input  logic             req1,
    input  logic [WIDTH-1:0] n1,
    input  logic [WIDTH-1:0] d1,
    output logic             ack0,
    output logic             ack1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] r0,
    output logic             dz0,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] r1,
    output logic             dz1,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic             pref;   // 1: client 1 wins a tie
    logic             owner;
    logic [WIDTH-1:0] nl;
    logic [WIDTH-1:0] dl;
    logic [WIDTH:0]   a;
    logic [WIDTH-1:0] qs;
    logic [CW-1:0]    cnt;

    logic             arb_en;
    logic             cand0;
    logic             cand1;
    logic             grant;
    logic             pick1;
    logic [WIDTH-1:0] sel_n;
    logic [WIDTH-1:0] sel_d;
    logic [WIDTH:0]   a_sh;
    logic             fits;
    logic [WIDTH:0]   a_nxt;

    // Arbitration also runs on the edge leaving DONE; the finishing owner is
    // masked there because its request may not have dropped yet.
    assign arb_en = (state == IDLE) || (state == DONE);
    assign cand0  = req0 && !((state == DONE) && (owner == 1'b0));
    assign cand1  = req1 && !((state == DONE) && (owner == 1'b1));
    assign grant  = arb_en && (cand0 || cand1);
    assign pick1  = cand1 && (!cand0 || pref);
    assign sel_n  = pick1 ? n1 : n0;
    assign sel_d  = pick1 ? d1 : d0;

    assign a_sh   = {a[WIDTH-1:0], qs[WIDTH-1]};
    assign fits   = (a_sh >= {1'b0, dl});
    assign a_nxt  = fits ? (a_sh - {1'b0, dl}) : a_sh;

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pref  <= 1'b0;
            owner <= 1'b0;
            nl    <= '0;
            dl    <= '0;
            a     <= '0;
            qs    <= '0;
            cnt   <= '0;
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            q0    <= '0;
            r0    <= '0;
            dz0   <= 1'b0;
            q1    <= '0;
            r1    <= '0;
            dz1   <= 1'b0;
        end else begin
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                ITER: begin
                    a   <= a_nxt;
                    qs  <= {qs[WIDTH-2:0], fits};
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= DONE;
                end
                DONE: begin
                    if (owner == 1'b0) begin
                        done0 <= 1'b1;
                        q0    <= (dl == '0) ? '1 : qs;
                        r0    <= (dl == '0) ? nl : a[WIDTH-1:0];
                        dz0   <= (dl == '0);
                    end else begin
                        done1 <= 1'b1;
                        q1    <= (dl == '0) ? '1 : qs;
                        r1    <= (dl == '0) ? nl : a[WIDTH-1:0];
                        dz1   <= (dl == '0);
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (grant) begin
                owner <= pick1;
                pref  <= ~pick1;
                nl    <= sel_n;
                dl    <= sel_d;
                a     <= '0;
                qs    <= sel_n;
                cnt   <= CW'(WIDTH);
                ack0  <= ~pick1;
                ack1  <= pick1;
                state <= (sel_d == '0) ? DONE : ITER;
            end
        end
    end

endmodule
